// File: rtl/sparc_exu_alu_zdet.sv
// Zero-detect stage after ALU sum-predict: group-OR reduction in E, icc/xcc Z in M,
// and a per-thread committed Z-flag register file with a non-bypassed read port.
module sparc_exu_alu_zdet #(
    parameter int unsigned NTHR = 4,
    parameter int unsigned GRP  = 16,
    localparam int unsigned TW  = (NTHR > 1) ? $clog2(NTHR) : 1
) (
    input  logic          rclk,
    input  logic          arst,
    input  logic [63:0]   spr_e,
    input  logic          vld_e,
    input  logic [TW-1:0] tid_e,
    input  logic          hold,
    input  logic          kill_e,
    input  logic          kill_m,
    output logic          vld_m,
    output logic [TW-1:0] tid_m,
    output logic          icc_z_m,
    output logic          xcc_z_m,
    input  logic [TW-1:0] rd_tid,
    output logic          icc_z_rd,
    output logic          xcc_z_rd
);

    localparam int unsigned NG = 64 / GRP;
    localparam int unsigned NL = 32 / GRP;

    logic [NG-1:0]   grp_nz_e;
    logic [NG-1:0]   grp_nz_m;
    logic [NTHR-1:0] ccz_icc;
    logic [NTHR-1:0] ccz_xcc;
    logic            wr_en;

    always_comb begin
        grp_nz_e = '0;
        for (int unsigned i = 0; i < NG; i++) begin
            grp_nz_e[i] = |spr_e[GRP*i +: GRP];
        end
    end

    // Reset loads all-ones group bits so both forwarded Z outputs read 0.
    always_ff @(posedge rclk or posedge arst) begin
        if (arst) begin
            vld_m    <= 1'b0;
            tid_m    <= '0;
            grp_nz_m <= '1;
        end else if (!hold) begin
            vld_m    <= vld_e & ~kill_e;
            tid_m    <= tid_e;
            grp_nz_m <= grp_nz_e;
        end
    end

    assign icc_z_m = ~|grp_nz_m[NL-1:0];
    assign xcc_z_m = ~|grp_nz_m;
    assign wr_en   = vld_m & ~kill_m & ~hold;

    // Decode by compare so an out-of-range thread ID writes and reads nothing.
    always_ff @(posedge rclk or posedge arst) begin
        if (arst) begin
            ccz_icc <= '0;
            ccz_xcc <= '0;
        end else begin
            for (int unsigned t = 0; t < NTHR; t++) begin
                if (wr_en && (tid_m == TW'(t))) begin
                    ccz_icc[t] <= icc_z_m;
                    ccz_xcc[t] <= xcc_z_m;
                end
            end
        end
    end

    always_comb begin
        icc_z_rd = 1'b0;
        xcc_z_rd = 1'b0;
        for (int unsigned t = 0; t < NTHR; t++) begin
            if (rd_tid == TW'(t)) begin
                icc_z_rd = ccz_icc[t];
                xcc_z_rd = ccz_xcc[t];
            end
        end
    end

endmodule

// File: tb/tb_sparc_exu_alu_zdet.sv
// Directed bench for sparc_exu_alu_zdet: reset, Z commit, group walk, kills, hold,
// back-to-back commits and asynchronous reset with an op in flight.
module tb_sparc_exu_alu_zdet;

    logic        rclk;
    logic        arst;
    logic [63:0] spr_e;
    logic        vld_e;
    logic [1:0]  tid_e;
    logic        hold;
    logic        kill_e;
    logic        kill_m;
    logic        vld_m;
    logic [1:0]  tid_m;
    logic        icc_z_m;
    logic        xcc_z_m;
    logic [1:0]  rd_tid;
    logic        icc_z_rd;
    logic        xcc_z_rd;

    int checks = 0;
    int failures = 0;

    sparc_exu_alu_zdet #(.NTHR(4), .GRP(16)) dut (
        .rclk     (rclk),
        .arst     (arst),
        .spr_e    (spr_e),
        .vld_e    (vld_e),
        .tid_e    (tid_e),
        .hold     (hold),
        .kill_e   (kill_e),
        .kill_m   (kill_m),
        .vld_m    (vld_m),
        .tid_m    (tid_m),
        .icc_z_m  (icc_z_m),
        .xcc_z_m  (xcc_z_m),
        .rd_tid   (rd_tid),
        .icc_z_rd (icc_z_rd),
        .xcc_z_rd (xcc_z_rd)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic chk_rd(input string tag, input logic [1:0] t, input logic ei, input logic ex);
        rd_tid = t;
        #1;
        chk({tag, "_icc_rd"}, icc_z_rd, ei);
        chk({tag, "_xcc_rd"}, xcc_z_rd, ex);
    endtask

    initial begin
        arst = 1'b1; spr_e = '0; vld_e = 1'b0; tid_e = '0;
        hold = 1'b0; kill_e = 1'b0; kill_m = 1'b0; rd_tid = '0;
        #1;
        chk("rst_vld", vld_m, 1'b0);
        chk("rst_tid", tid_m, 2'd0);
        chk("rst_icc_m", icc_z_m, 1'b0);
        chk("rst_xcc_m", xcc_z_m, 1'b0);
        for (int t = 0; t < 4; t++) chk_rd("rst", 2'(t), 1'b0, 1'b0);
        #8 arst = 1'b0;

        // zero result on tid 2
        spr_e = 64'h0; vld_e = 1'b1; tid_e = 2'd2;
        tick();
        chk("z_vld", vld_m, 1'b1);
        chk("z_tid", tid_m, 2'd2);
        chk("z_icc_m", icc_z_m, 1'b1);
        chk("z_xcc_m", xcc_z_m, 1'b1);
        chk_rd("z_pre", 2'd2, 1'b0, 1'b0);
        vld_e = 1'b0;
        tick();
        chk_rd("z_post", 2'd2, 1'b1, 1'b1);

        // upper-half nonzero on tid 2
        spr_e = 64'h0000_0001_0000_0000; vld_e = 1'b1; tid_e = 2'd2;
        tick();
        chk("hi_icc_m", icc_z_m, 1'b1);
        chk("hi_xcc_m", xcc_z_m, 1'b0);
        vld_e = 1'b0;
        tick();
        chk_rd("hi_post", 2'd2, 1'b1, 1'b0);

        // single-bit walk, not committed
        for (int b = 0; b < 64; b++) begin
            spr_e = 64'd1 << b;
            tick();
            chk($sformatf("walk%0d_icc", b), icc_z_m, (b >= 32) ? 1'b1 : 1'b0);
            chk($sformatf("walk%0d_xcc", b), xcc_z_m, 1'b0);
        end
        chk("walk_vld", vld_m, 1'b0);

        // kill_e on tid 1
        spr_e = 64'h0; vld_e = 1'b1; tid_e = 2'd1; kill_e = 1'b1;
        tick();
        chk("ke_vld", vld_m, 1'b0);
        vld_e = 1'b0; kill_e = 1'b0;
        tick();
        chk_rd("ke", 2'd1, 1'b0, 1'b0);

        // kill_m on tid 3
        spr_e = 64'h0; vld_e = 1'b1; tid_e = 2'd3;
        tick();
        chk("km_vld", vld_m, 1'b1);
        vld_e = 1'b0; kill_m = 1'b1;
        tick();
        kill_m = 1'b0;
        chk("km_adv", vld_m, 1'b0);
        chk_rd("km", 2'd3, 1'b0, 1'b0);

        // hold for 3 cycles with tid-1 op presented
        spr_e = 64'h0; vld_e = 1'b1; tid_e = 2'd0;
        tick();
        hold = 1'b1; spr_e = 64'h1; tid_e = 2'd1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("hold%0d_vld", c), vld_m, 1'b1);
            chk($sformatf("hold%0d_tid", c), tid_m, 2'd0);
            chk($sformatf("hold%0d_icc", c), icc_z_m, 1'b1);
            chk($sformatf("hold%0d_xcc", c), xcc_z_m, 1'b1);
            chk_rd($sformatf("hold%0d", c), 2'd0, 1'b0, 1'b0);
        end
        hold = 1'b0;
        tick();
        chk("rel_vld", vld_m, 1'b1);
        chk("rel_tid", tid_m, 2'd1);
        chk("rel_icc_m", icc_z_m, 1'b0);
        chk("rel_xcc_m", xcc_z_m, 1'b0);
        chk_rd("rel", 2'd0, 1'b1, 1'b1);
        vld_e = 1'b0;
        tick();
        chk_rd("rel_t1", 2'd1, 1'b0, 1'b0);

        // back-to-back on tid 1: Z=1 then Z=0
        spr_e = 64'h0; vld_e = 1'b1; tid_e = 2'd1;
        tick();
        spr_e = 64'hFF;
        tick();
        chk_rd("b2b_1", 2'd1, 1'b1, 1'b1);
        vld_e = 1'b0;
        tick();
        chk_rd("b2b_0", 2'd1, 1'b0, 1'b0);
        chk_rd("b2b_t0", 2'd0, 1'b1, 1'b1);
        chk_rd("b2b_t2", 2'd2, 1'b1, 1'b0);
        chk_rd("b2b_t3", 2'd3, 1'b0, 1'b0);

        // async reset with a valid op in M
        spr_e = 64'h0; vld_e = 1'b1; tid_e = 2'd3;
        tick();
        vld_e = 1'b0;
        chk("ar_pre_vld", vld_m, 1'b1);
        #1 arst = 1'b1;
        #1;
        chk("ar_vld", vld_m, 1'b0);
        chk("ar_tid", tid_m, 2'd0);
        chk("ar_icc_m", icc_z_m, 1'b0);
        chk("ar_xcc_m", xcc_z_m, 1'b0);
        for (int t = 0; t < 4; t++) chk_rd($sformatf("ar%0d", t), 2'(t), 1'b0, 1'b0);
        tick();
        arst = 1'b0;
        tick();
        chk_rd("ar_post", 2'd3, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sparc_exu_alu_zdet.md
Name: sparc_exu_alu_zdet

Overview:
- Pipelined zero-detect stage that sits directly downstream of the ALU sum-predict logic.
- Takes the 64-bit sum-predict vector in E, where the vector is all-zero iff the adder result is zero.
- Produces registered icc.Z (low 32 bits) and xcc.Z (all 64 bits) in M.
- Commits them into a per-thread Z-flag register file read by the CC/branch logic.

Parameters:
- NTHR, 4, number of hardware threads; the thread-ID width is log2(NTHR).
- GRP, 16, reduction group width in bits; must divide 32.

Ports:
- rclk  in  1  clock; all state updates on the rising edge
- arst  in  1  reset, asynchronous, active-high
- spr_e  in  64  sum-predict vector from the sum-predict stage
- vld_e  in  1  E-stage op valid; the op sets CC
- tid_e  in  log2(NTHR)  thread of the E op
- hold  in  1  pipeline stall; freezes the M register
- kill_e  in  1  squash the E op; it does not enter M
- kill_m  in  1  squash the M op; no commit
- vld_m  out  1  M op valid (registered, kill_m not applied)
- tid_m  out  log2(NTHR)  thread of the M op
- icc_z_m  out  1  forwarded icc.Z of the M op
- xcc_z_m  out  1  forwarded xcc.Z of the M op
- rd_tid  in  log2(NTHR)  read-port thread select
- icc_z_rd  out  1  committed icc.Z for rd_tid
- xcc_z_rd  out  1  committed xcc.Z for rd_tid

Behaviour:
- E stage, combinational:
  - grp_nz[i] = OR of spr_e[GRP*i +: GRP], for i = 0..64/GRP-1.
- E→M register:
  - Holds grp_nz, tid, and valid.
  - On a rising edge with hold=0, it loads grp_nz, tid_e, and (vld_e & ~kill_e).
  - With hold=1 it retains all contents, including valid.
- M stage outputs, combinational from the M register:
  - icc_z_m = NOR of the low 32/GRP group bits.
  - xcc_z_m = NOR of all group bits.
- Latency: exactly one cycle, E→M.
- Commit:
  - At the end of M, if vld_m & ~kill_m & ~hold, write ccz_icc[tid_m] = icc_z_m and ccz_xcc[tid_m] = xcc_z_m.
  - Only the M-register entry is consumed on commit. Under hold, nothing commits, so a held op commits exactly once after hold drops.
- kill_m:
  - Blocks the commit only.
  - The M register advances normally when hold=0.
  - kill_m with hold=1: no commit, and the op remains in M. kill_m must be re-asserted by the controller every cycle the op is to stay squashed; the block does not remember it.
- kill_e with hold=1: no effect. The E op does not load, and the M contents stay unchanged.
- Read port:
  - icc_z_rd and xcc_z_rd = ccz_*[rd_tid] from the register file only; there is no bypass.
  - A commit to a thread is visible on the read port in the cycle after the commit edge.
  - Consumers needing same-cycle data use the *_m forward outputs.
- Back-to-back ops on the same thread: the later commit overwrites the earlier one; no hazard logic.
- Reset (arst=1, asynchronous):
  - vld_m=0, tid_m=0, and grp_nz regs=all 1s, so icc_z_m=0 and xcc_z_m=0.
  - All ccz_icc and ccz_xcc entries = 0, so the read outputs = 0.
  - Reset asserted mid-op discards the in-flight op; no partial commit.
  - After arst deasserts, the first rising edge behaves as normal.
- Out-of-range rd_tid or tid_e (NTHR not a power of two) reads or writes nothing; the read returns 0.

Test Plan:
- Reset: assert arst asynchronously mid-cycle with a valid op in M. Required response:
  - vld_m, icc_z_m, xcc_z_m, and all read values go to 0 immediately.
  - No commit occurs.
- Zero/nonzero commit: drive spr_e=0, vld_e=1, tid_e=2. Required response:
  - Next cycle: vld_m=1, tid_m=2, icc_z_m=1, xcc_z_m=1.
  - Following cycle: rd_tid=2 gives icc_z_rd=1, xcc_z_rd=1.
  - Then spr_e=64'h0000_0001_0000_0000 on tid 2 gives icc.Z=1, xcc.Z=0.
- Group boundaries: walk a single 1 across each of the 64 bit positions. Required response:
  - Bits 0–31 give icc_z_m=0 and xcc_z_m=0.
  - Bits 32–63 give icc_z_m=1 and xcc_z_m=0.
- Kills:
  - kill_e with spr_e=0 on tid 1: next cycle vld_m=0, and ccz[1] is unchanged.
  - kill_m on a valid M op on tid 3: read value of tid 3 is unchanged.
- Hold: load an op with spr_e=0 on tid 0, then hold=1 for 3 cycles while vld_e presents spr_e=1 on tid 1. Required response:
  - M keeps tid 0, Z=1, for all 3 cycles with no commit.
  - On release, tid 0 commits once, and the tid-1 op (presented with hold=0) enters M.
- Back-to-back: on thread 1, commit Z=1 and then Z=0 on consecutive cycles. Required response:
  - The read port shows 1, then 0, each one cycle after its commit edge.
  - The other threads keep their values.
